// File: rtl/rule_unpacker_128_32_pkg.sv
// -----------------------------------------------------------------------------
// rule_unpacker_128_32_pkg
// Shared constants and helpers for the rule-load width converters (128<->32).
// Contents:
//   IN_W / OUT_W / LANES / LW  beat width, word width, words per beat, lane index width
//   LANE_FIRST                 lane that travels first on the narrow side (data[OUT_W-1:0])
//   frame_state_t              packet framing state (outside / inside a packet)
//   beat_tail_t                last lane and byte-empty of the final word of a beat
//   eop_tail()                 converts a beat's byte-empty into a beat_tail_t
// -----------------------------------------------------------------------------
package rule_unpacker_128_32_pkg;

   localparam int IN_W       = 128;
   localparam int OUT_W      = 32;
   localparam int LANES      = IN_W / OUT_W;
   localparam int LW         = $clog2(LANES);
   // Lane 0 (least significant word) goes first; the 32->128 packer fills in
   // the same order so the two converters are exact inverses.
   localparam int LANE_FIRST = 0;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } frame_state_t;

   typedef struct packed {
      logic [LW-1:0] last_lane;
      logic [1:0]    last_empty;
   } beat_tail_t;

   // Byte-empty of an eop beat -> index of its last valid word and the unused
   // bytes inside that word. empty is at most 15, so at least one byte is valid.
   function automatic beat_tail_t eop_tail(input logic [3:0] empty);
      logic [4:0] valid_bytes;
      beat_tail_t t;
      valid_bytes  = 5'd16 - {1'b0, empty};
      t.last_lane  = LW'((valid_bytes - 5'd1) >> 2);
      // (4 - valid_bytes % 4) % 4: the 2-bit truncation performs the outer mod
      t.last_empty = 2'(3'd4 - {1'b0, valid_bytes[1:0]});
      return t;
   endfunction

endpackage

// File: rtl/rule_unpacker_128_32.sv
// -----------------------------------------------------------------------------
// rule_unpacker_128_32
// Width-down converter on the host->FPGA rule path: accepts 128-bit
// Avalon-ST beats and emits them as 32-bit words, lane 0 first. Partial eop
// beats emit only the words holding valid bytes. Framing violations are
// flagged with a one-cycle pulse while the data is still forwarded.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_rule_sop/eop/empty/valid/data  128-bit input beat (empty used on eop only)
//   in_rule_ready                     input accepted when valid && ready
//   out_rule_sop/eop/empty/valid/data 32-bit output word (empty 0 unless eop)
//   out_rule_ready                    downstream accepts when valid && ready
//   frame_err                         pulse: non-sop beat outside a packet, or
//                                     sop beat inside a packet
// -----------------------------------------------------------------------------
module rule_unpacker_128_32
   import rule_unpacker_128_32_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_rule_sop,
   input  logic              in_rule_eop,
   input  logic [3:0]        in_rule_empty,
   input  logic              in_rule_valid,
   input  logic [IN_W-1:0]   in_rule_data,
   output logic              in_rule_ready,
   output logic              out_rule_sop,
   output logic              out_rule_eop,
   output logic [1:0]        out_rule_empty,
   output logic              out_rule_valid,
   output logic [OUT_W-1:0]  out_rule_data,
   input  logic              out_rule_ready,
   output logic              frame_err
);

   // Holding register for one beat plus the lane currently presented.
   logic [IN_W-1:0] buf_data;
   logic            buf_sop;
   logic            buf_eop;
   logic [LW-1:0]   buf_last_lane;
   logic [1:0]      buf_last_empty;
   logic            buf_valid;
   logic [LW-1:0]   lane;

   frame_state_t    state;
   beat_tail_t      tail;
   logic            at_last;
   logic            in_accept;
   logic            out_xfer;

   assign at_last   = (lane == buf_last_lane);
   // A new beat may land in the same cycle the last word of the current one
   // leaves, which keeps the stream gap-free at one beat per LANES cycles.
   assign in_rule_ready = !buf_valid || (out_rule_ready && at_last);
   assign in_accept = in_rule_valid && in_rule_ready;
   assign out_xfer  = buf_valid && out_rule_ready;

   // NOTE: tail is assigned on every path through the block, so no latch is inferred.
   always_comb begin
      tail.last_lane  = LW'(LANES - 1);
      tail.last_empty = 2'd0;
      if (in_rule_eop) begin
         tail = eop_tail(in_rule_empty);
      end
   end

   // Outputs decode registered state only and read as zero while empty.
   assign out_rule_valid = buf_valid;
   assign out_rule_data  = buf_valid ? buf_data[int'(lane) * OUT_W +: OUT_W] : '0;
   assign out_rule_sop   = buf_valid && buf_sop && (lane == LW'(LANE_FIRST));
   assign out_rule_eop   = buf_valid && buf_eop && at_last;
   assign out_rule_empty = out_rule_eop ? buf_last_empty : 2'd0;

   // NOTE: payload registers have no reset; every output use is qualified by buf_valid.
   always_ff @(posedge clk) begin
      if (in_accept) begin
         buf_data       <= in_rule_data;
         buf_sop        <= in_rule_sop;
         buf_eop        <= in_rule_eop;
         buf_last_lane  <= tail.last_lane;
         buf_last_empty <= tail.last_empty;
      end
   end

   // NOTE: non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid <= 1'b0;
         lane      <= LW'(LANE_FIRST);
      end else if (in_accept) begin
         buf_valid <= 1'b1;
         lane      <= LW'(LANE_FIRST);
      end else if (out_xfer) begin
         if (at_last) begin
            buf_valid <= 1'b0;
            lane      <= LW'(LANE_FIRST);
         end else begin
            lane      <= lane + LW'(1);
         end
      end
   end

   // Framing tracker: moves only on an accepted beat. The next state follows
   // the beat's eop in both states; the error depends on sop versus state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (in_accept) begin
            case (state)
               ST_IDLE:   frame_err <= !in_rule_sop;
               ST_IN_PKT: frame_err <= in_rule_sop;
               default:   frame_err <= 1'b0;
            endcase
            state <= in_rule_eop ? ST_IDLE : ST_IN_PKT;
         end
      end
   end

endmodule

// File: tb/tb_rule_unpacker_128_32.sv
// -----------------------------------------------------------------------------
// tb_rule_unpacker_128_32
// Self-checking bench for rule_unpacker_128_32. A negedge monitor expands each
// accepted beat into its expected words (plain arithmetic on byte counts),
// tracks packet framing, and compares every transferred word, the frame_err
// pulse and output stability under backpressure. Directed sections cover the
// exact timing cases; a random section adds stalls, gaps and framing faults.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rule_unpacker_128_32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_rule_sop;
   logic         in_rule_eop;
   logic [3:0]   in_rule_empty;
   logic         in_rule_valid;
   logic [127:0] in_rule_data;
   logic         in_rule_ready;
   logic         out_rule_sop;
   logic         out_rule_eop;
   logic [1:0]   out_rule_empty;
   logic         out_rule_valid;
   logic [31:0]  out_rule_data;
   logic         out_rule_ready;
   logic         frame_err;

   rule_unpacker_128_32 dut (
      .clk            (clk),
      .rst            (rst),
      .in_rule_sop    (in_rule_sop),
      .in_rule_eop    (in_rule_eop),
      .in_rule_empty  (in_rule_empty),
      .in_rule_valid  (in_rule_valid),
      .in_rule_data   (in_rule_data),
      .in_rule_ready  (in_rule_ready),
      .out_rule_sop   (out_rule_sop),
      .out_rule_eop   (out_rule_eop),
      .out_rule_empty (out_rule_empty),
      .out_rule_valid (out_rule_valid),
      .out_rule_data  (out_rule_data),
      .out_rule_ready (out_rule_ready),
      .frame_err      (frame_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
      logic [31:0] data;
   } word_t;

   word_t exp_q[$];
   bit    in_pkt     = 1'b0;
   bit    exp_err    = 1'b0;
   bit    prev_stall = 1'b0;
   word_t prev_word;
   int    cyc        = 0;
   bit    log_en     = 1'b0;
   int    xfer_log[$];
   int    rdy_log[$];
   bit    rand_mode  = 1'b0;

   function automatic word_t cur_word();
      word_t w;
      w.sop   = out_rule_sop;
      w.eop   = out_rule_eop;
      w.empty = out_rule_empty;
      w.data  = out_rule_data;
      return w;
   endfunction

   // Reference: a beat carries valid_bytes bytes, i.e. ceil(valid_bytes/4)
   // words; the last word's empty is the padding up to a whole word.
   task automatic push_beat(input logic [127:0] d, input logic s, input logic e,
                            input logic [3:0] em);
      int vb;
      int n;
      word_t w;
      vb = e ? 16 - int'(em) : 16;
      n  = (vb + 3) / 4;
      for (int k = 0; k < n; k++) begin
         w.data  = d[32*k +: 32];
         w.sop   = s && (k == 0);
         w.eop   = e && (k == n - 1);
         w.empty = w.eop ? 2'(4 * n - vb) : 2'd0;
         exp_q.push_back(w);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         exp_q.delete();
         in_pkt     = 1'b0;
         exp_err    = 1'b0;
         prev_stall = 1'b0;
      end else begin
         check("frame_err", 64'(frame_err), 64'(exp_err));
         exp_err = 1'b0;
         if (prev_stall) begin
            check("stall_valid", 64'(out_rule_valid), 64'(1));
            check("stall_hold", 64'(cur_word()), 64'(prev_word));
         end
         if (in_rule_valid && in_rule_ready) begin
            exp_err = in_pkt ? in_rule_sop : !in_rule_sop;
            in_pkt  = !in_rule_eop;
            push_beat(in_rule_data, in_rule_sop, in_rule_eop, in_rule_empty);
         end
         if (log_en && in_rule_ready) rdy_log.push_back(cyc);
         if (out_rule_valid && out_rule_ready) begin
            if (log_en) xfer_log.push_back(cyc);
            check("word_avail", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) check("word", 64'(cur_word()), 64'(exp_q.pop_front()));
         end
         prev_stall = out_rule_valid && !out_rule_ready;
         prev_word  = cur_word();
      end
   end

   // Downstream ready: changed just after each rising edge.
   initial begin
      out_rule_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_rule_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered and left at posedge+1; returns right after the accepting edge.
   task automatic send_beat(input logic [127:0] d, input logic s, input logic e,
                            input logic [3:0] em);
      int n;
      n             = 0;
      in_rule_data  = d;
      in_rule_sop   = s;
      in_rule_eop   = e;
      in_rule_empty = em;
      in_rule_valid = 1'b1;
      #1;
      while (!in_rule_ready && n < 1000) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 1000) check("send_timeout", 64'(n), 64'(0));
      @(posedge clk);
      #1;
      in_rule_valid = 1'b0;
   endtask

   logic [127:0] d;
   int           hits[$];

   initial begin
      rst           = 1'b1;
      in_rule_sop   = 1'b0;
      in_rule_eop   = 1'b0;
      in_rule_empty = 4'd0;
      in_rule_valid = 1'b0;
      in_rule_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      #1;
      check("rst_out_valid", 64'(out_rule_valid), 64'(0));
      check("rst_in_ready",  64'(in_rule_ready),  64'(1));
      check("rst_out_data",  64'(out_rule_data),  64'(0));
      check("rst_sop_eop",   64'({out_rule_sop, out_rule_eop}), 64'(0));
      check("rst_frame_err", 64'(frame_err), 64'(0));
      tick();

      // Full single-beat packet: four words, ready low for the first three
      d = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
      send_beat(d, 1'b1, 1'b1, 4'd0);
      for (int k = 0; k < 4; k++) begin
         #1;
         check("full_valid", 64'(out_rule_valid), 64'(1));
         check("full_data",  64'(out_rule_data),  64'(d[32*k +: 32]));
         check("full_sop",   64'(out_rule_sop),   64'(k == 0));
         check("full_eop",   64'(out_rule_eop),   64'(k == 3));
         check("full_ready", 64'(in_rule_ready),  64'(k == 3));
         tick();
      end
      #1;
      check("full_done", 64'(out_rule_valid), 64'(0));
      tick();

      // empty=6: 10 bytes -> 3 words, last with 2 empty bytes
      d = {32'hEEEE_EEEE, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
      send_beat(d, 1'b1, 1'b1, 4'd6);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("e6_data",  64'(out_rule_data),  64'(d[32*k +: 32]));
         check("e6_eop",   64'(out_rule_eop),   64'(k == 2));
         check("e6_empty", 64'(out_rule_empty), 64'((k == 2) ? 2 : 0));
         tick();
      end
      #1;
      check("e6_done", 64'(out_rule_valid), 64'(0));
      tick();

      // empty=12: one word carrying both sop and eop
      d = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hC0C0_C0C0};
      send_beat(d, 1'b1, 1'b1, 4'd12);
      #1;
      check("e12_data",    64'(out_rule_data), 64'(32'hC0C0_C0C0));
      check("e12_sop_eop", 64'({out_rule_sop, out_rule_eop}), 64'(2'b11));
      check("e12_empty",   64'(out_rule_empty), 64'(0));
      tick();
      #1;
      check("e12_done", 64'(out_rule_valid), 64'(0));
      tick();

      // Back-to-back 3-beat packet: 12 gap-free words, ready only on last lanes
      xfer_log.delete();
      rdy_log.delete();
      log_en = 1'b1;
      send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 4'd0);
      send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 4'd0);
      send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 4'd0);
      repeat (6) tick();
      log_en = 1'b0;
      check("b2b_words", 64'(xfer_log.size()), 64'(12));
      if (xfer_log.size() == 12) begin
         check("b2b_span", 64'(xfer_log[11] - xfer_log[0]), 64'(11));
         hits.delete();
         foreach (rdy_log[i])
            if (rdy_log[i] >= xfer_log[0] && rdy_log[i] <= xfer_log[11]) hits.push_back(rdy_log[i]);
         check("b2b_rdy_count", 64'(hits.size()), 64'(3));
         if (hits.size() == 3)
            for (int i = 0; i < 3; i++) check("b2b_rdy_cycle", 64'(hits[i]), 64'(xfer_log[4*i+3]));
      end

      // Non-sop beat outside a packet: error pulse, words still forwarded
      send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 4'd0);
      #1;
      check("nonsop_err",   64'(frame_err), 64'(1));
      check("nonsop_valid", 64'(out_rule_valid), 64'(1));
      tick();
      #1;
      check("nonsop_pulse", 64'(frame_err), 64'(0));
      tick();
      repeat (3) tick();

      // sop inside a packet
      send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 4'd0);
      send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 4'd0);
      #1;
      check("midsop_err", 64'(frame_err), 64'(1));
      tick();
      repeat (4) tick();

      // Reset while lane 2 is presented: beat dropped, no eop
      d = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
      send_beat(d, 1'b1, 1'b0, 4'd0);
      tick();
      tick();
      #1;
      check("pre_rst_lane2", 64'(out_rule_data), 64'(32'h7777_0002));
      #1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_rule_valid), 64'(0));
      check("mid_rst_ready", 64'(in_rule_ready),  64'(1));
      check("mid_rst_eop",   64'(out_rule_eop),   64'(0));
      tick();
      d = {32'h8888_0003, 32'h8888_0002, 32'h8888_0001, 32'h8888_0000};
      send_beat(d, 1'b1, 1'b1, 4'd0);
      #1;
      check("post_rst_data", 64'(out_rule_data), 64'(32'h8888_0000));
      check("post_rst_sop",  64'(out_rule_sop),  64'(1));
      tick();
      repeat (4) tick();

      // Random packets with 50% downstream stalls, gaps and framing faults
      rand_mode = 1'b1;
      for (int p = 0; p < 60; p++) begin
         int nb;
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            logic s;
            logic e;
            s = (b == 0) ^ ($urandom_range(0, 9) == 0);
            e = (b == nb - 1);
            send_beat({$urandom, $urandom, $urandom, $urandom}, s, e, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) tick();
         end
      end
      begin
         int n;
         n = 0;
         while ((exp_q.size() != 0 || out_rule_valid) && n < 500) begin
            tick();
            n++;
         end
         if (n >= 500) check("drain_timeout", 64'(n), 64'(0));
      end
      check("drain_empty", 64'(exp_q.size()), 64'(0));
      rand_mode = 1'b0;
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
